// File: rtl/lms_seq_ctrl.sv
// lms_seq_ctrl: sequencer for the fractionally-spaced equalizer's LMS tap
// update. Turns the T/2 sample strobe into rx-enable, shift, save and
// tap-update strobes, handles startup fill, update decimation, freeze and
// overrun detection when a new save arrives before the previous update fired.
module lms_seq_ctrl #(
    parameter int NUM_TAPS = 9,
    parameter int ERR_LAT  = 3,
    parameter int UPD_DIV  = 1,
    parameter int NB_CNT   = 16
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_valid,
    input  logic              i_phase_sel,
    input  logic              i_freeze,
    output logic              o_en_rx,
    output logic              o_en_shtr,
    output logic              o_save_shftrs,
    output logic              o_en_taps,
    output logic [1:0]        o_state,
    output logic [NB_CNT-1:0] o_upd_cnt,
    output logic              o_overrun
);

    localparam int FILL_W = $clog2(NUM_TAPS + 1);
    localparam int LAT_W  = $clog2(ERR_LAT + 1);
    localparam int DIV_W  = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_ADAPT  = 2'd2,
        ST_FREEZE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                en_rx_q, en_rx_d;
    logic                phase_q, phase_d;
    logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                save_q, save_d;
    logic                pending_q, pending_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic                en_taps_q, en_taps_d;
    logic [NB_CNT-1:0]   upd_cnt_q, upd_cnt_d;
    logic                overrun_q, overrun_d;

    logic accept;
    logic is_symbol;
    logic adapt_symbol;
    logic adapt_start;

    // Sample qualification: a sample counts only while the datapath is enabled,
    // and the divider/save logic only acts on symbol samples seen in ADAPT.
    always_comb begin
        accept       = i_valid & en_rx_q;
        is_symbol    = accept & (phase_q == i_phase_sel);
        adapt_symbol = is_symbol & (state_q == ST_ADAPT) & ~i_freeze;
        adapt_start  = adapt_symbol & (div_cnt_q == '0);
    end

    // Next-state logic for the mode FSM, divider, save/update pipeline and stats.
    always_comb begin
        state_d    = state_q;
        en_rx_d    = i_enable;
        phase_d    = phase_q;
        fill_cnt_d = fill_cnt_q;
        div_cnt_d  = div_cnt_q;
        save_d     = adapt_start;
        pending_d  = pending_q;
        lat_cnt_d  = lat_cnt_q;
        en_taps_d  = 1'b0;
        upd_cnt_d  = upd_cnt_q;
        overrun_d  = overrun_q;

        // Phase alternates per accepted sample and restarts at 0 on every enable.
        if (!en_rx_q) begin
            phase_d = 1'b0;
        end else if (accept) begin
            phase_d = ~phase_q;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FILL;
            end
            ST_FILL: begin
                if (accept) begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == FILL_W'(NUM_TAPS - 1)) begin
                        state_d = i_freeze ? ST_FREEZE : ST_ADAPT;
                    end
                end
            end
            ST_ADAPT: begin
                if (i_freeze) begin
                    state_d = ST_FREEZE;
                end
            end
            ST_FREEZE: begin
                if (!i_freeze) begin
                    state_d = ST_ADAPT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Decimation: only symbols seen while actively adapting advance it.
        if (adapt_symbol) begin
            if (div_cnt_q == DIV_W'(UPD_DIV - 1)) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end

        // Update pipeline: the tap strobe fires ERR_LAT cycles after the save.
        // A save always restarts the countdown; if the previous update is still
        // outstanding and not firing right now, it is lost and flagged.
        if (save_q) begin
            pending_d = 1'b1;
            lat_cnt_d = LAT_W'(ERR_LAT - 1);
            en_taps_d = (ERR_LAT == 1);
            if (pending_q && !en_taps_q) begin
                overrun_d = 1'b1;
            end
        end else begin
            if (en_taps_q) begin
                pending_d = 1'b0;
            end
            if (lat_cnt_q != '0) begin
                lat_cnt_d = lat_cnt_q - 1'b1;
            end
            en_taps_d = pending_q & (lat_cnt_q == LAT_W'(1));
        end

        if (en_taps_q && (upd_cnt_q != '1)) begin
            upd_cnt_d = upd_cnt_q + 1'b1;
        end

        // Enable drop returns to IDLE and cancels anything in flight.
        if (!i_enable) begin
            state_d    = ST_IDLE;
            phase_d    = 1'b0;
            fill_cnt_d = '0;
            div_cnt_d  = '0;
            save_d     = 1'b0;
            pending_d  = 1'b0;
            lat_cnt_d  = '0;
            en_taps_d  = 1'b0;
            upd_cnt_d  = '0;
            overrun_d  = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            en_rx_q    <= 1'b0;
            phase_q    <= 1'b0;
            fill_cnt_q <= '0;
            div_cnt_q  <= '0;
            save_q     <= 1'b0;
            pending_q  <= 1'b0;
            lat_cnt_q  <= '0;
            en_taps_q  <= 1'b0;
            upd_cnt_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_rx_q    <= en_rx_d;
            phase_q    <= phase_d;
            fill_cnt_q <= fill_cnt_d;
            div_cnt_q  <= div_cnt_d;
            save_q     <= save_d;
            pending_q  <= pending_d;
            lat_cnt_q  <= lat_cnt_d;
            en_taps_q  <= en_taps_d;
            upd_cnt_q  <= upd_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_en_rx       = en_rx_q;
    assign o_en_shtr     = accept;
    assign o_save_shftrs = save_q;
    assign o_en_taps     = en_taps_q;
    assign o_state       = state_q;
    assign o_upd_cnt     = upd_cnt_q;
    assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_lms_seq_ctrl.sv
// Testbench for lms_seq_ctrl: three parameterisations driven in lockstep
// (baseline, UPD_DIV=4, ERR_LAT=2 with a 4-bit counter), checked every cycle
// against an event-level model plus hand-computed spot values.
module tb_lms_seq_ctrl;

    localparam int NUM_TAPS = 9;
    localparam int NCFG     = 3;

    logic clk         = 1'b0;
    logic rst_n       = 1'b0;
    logic i_enable    = 1'b0;
    logic i_valid     = 1'b0;
    logic i_phase_sel = 1'b0;
    logic i_freeze    = 1'b0;

    always #5 clk = ~clk;

    logic        act_en_rx   [NCFG];
    logic        act_en_shtr [NCFG];
    logic        act_save    [NCFG];
    logic        act_taps    [NCFG];
    logic        act_ovr     [NCFG];
    logic [1:0]  act_state   [NCFG];
    logic [15:0] act_cnt     [NCFG];

    function automatic int cfg_lat(int i); return (i == 2) ? 2 : 3; endfunction
    function automatic int cfg_div(int i); return (i == 1) ? 4 : 1; endfunction
    function automatic int cfg_max(int i); return (i == 2) ? 15 : 65535; endfunction

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
        localparam int LAT = (gi == 2) ? 2 : 3;
        localparam int DIV = (gi == 1) ? 4 : 1;
        localparam int NBC = (gi == 2) ? 4 : 16;
        logic [NBC-1:0] cnt_w;
        lms_seq_ctrl #(
            .NUM_TAPS(NUM_TAPS), .ERR_LAT(LAT), .UPD_DIV(DIV), .NB_CNT(NBC)
        ) u_dut (
            .clk(clk), .i_reset(rst_n), .i_enable(i_enable), .i_valid(i_valid),
            .i_phase_sel(i_phase_sel), .i_freeze(i_freeze),
            .o_en_rx(act_en_rx[gi]), .o_en_shtr(act_en_shtr[gi]),
            .o_save_shftrs(act_save[gi]), .o_en_taps(act_taps[gi]),
            .o_state(act_state[gi]), .o_upd_cnt(cnt_w), .o_overrun(act_ovr[gi])
        );
        assign act_cnt[gi] = 16'(cnt_w);
    end

    // Model: tracks accepted-sample count since enable, frozen level, symbols
    // seen while adapting, and the cycle number at which the outstanding
    // update is due.
    bit m_en   [NCFG];
    int m_nacc [NCFG];
    bit m_frz  [NCFG];
    int m_nsym [NCFG];
    bit m_save [NCFG];
    int m_due  [NCFG];
    int m_cnt  [NCFG];
    bit m_ovr  [NCFG];
    int cyc = 0;

    initial begin
        bit acc, sym, adapting, start, taps_now;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NCFG; i++) begin
                    m_en[i] = 0; m_nacc[i] = 0; m_frz[i] = 0; m_nsym[i] = 0;
                    m_save[i] = 0; m_due[i] = -1; m_cnt[i] = 0; m_ovr[i] = 0;
                end
            end else begin
                for (int i = 0; i < NCFG; i++) begin
                    acc      = i_valid && m_en[i];
                    sym      = acc && ((m_nacc[i] % 2) == int'(i_phase_sel));
                    adapting = m_en[i] && (m_nacc[i] >= NUM_TAPS) && !m_frz[i] && !i_freeze;
                    start    = sym && adapting && ((m_nsym[i] % cfg_div(i)) == 0);
                    taps_now = (m_due[i] == cyc);
                    if (!i_enable) begin
                        m_en[i] = 0; m_nacc[i] = 0; m_frz[i] = 0; m_nsym[i] = 0;
                        m_save[i] = 0; m_due[i] = -1; m_cnt[i] = 0; m_ovr[i] = 0;
                    end else begin
                        if (taps_now && m_cnt[i] < cfg_max(i)) m_cnt[i]++;
                        if (m_save[i]) begin
                            if (m_due[i] != -1 && !taps_now) m_ovr[i] = 1;
                            m_due[i] = cyc + cfg_lat(i);
                        end else if (taps_now) begin
                            m_due[i] = -1;
                        end
                        if (sym && adapting) m_nsym[i]++;
                        if (acc) m_nacc[i]++;
                        m_save[i] = start;
                        m_en[i]   = 1;
                        m_frz[i]  = i_freeze;
                    end
                end
                cyc++;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, int i, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cfg%0d: got %0d, want %0d at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int exp_state;
        for (int i = 0; i < NCFG; i++) begin
            exp_state = !m_en[i] ? 0 : ((m_nacc[i] < NUM_TAPS) ? 1 : (m_frz[i] ? 3 : 2));
            chk("en_rx",   i, int'(act_en_rx[i]),   int'(m_en[i]));
            chk("en_shtr", i, int'(act_en_shtr[i]), int'(i_valid && m_en[i]));
            chk("save",    i, int'(act_save[i]),    int'(m_save[i]));
            chk("en_taps", i, int'(act_taps[i]),    int'(m_due[i] == cyc));
            chk("state",   i, int'(act_state[i]),   exp_state);
            chk("upd_cnt", i, int'(act_cnt[i]),     m_cnt[i]);
            chk("overrun", i, int'(act_ovr[i]),     int'(m_ovr[i]));
        end
    endtask

    // One cycle: compare on the falling edge, return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int nb, ns;

        // Reset state
        repeat (3) tick();
        for (int i = 0; i < NCFG; i++) begin
            chk("rst_state", i, int'(act_state[i]), 0);
            chk("rst_en_rx", i, int'(act_en_rx[i]), 0);
            chk("rst_cnt",   i, int'(act_cnt[i]),   0);
            chk("rst_ovr",   i, int'(act_ovr[i]),   0);
        end
        rst_n = 1'b1;
        tick();

        // Startup: enable, samples every 2 cycles, symbol phase 0
        i_enable = 1'b1;
        tick();
        chk("start_en_rx", 0, int'(act_en_rx[0]), 1);
        chk("start_fill",  0, int'(act_state[0]), 1);
        for (int j = 1; j <= 9; j++) begin
            i_valid = 1'b1; tick();
            i_valid = 1'b0; tick();
        end
        chk("start_adapt", 0, int'(act_state[0]), 2);
        i_valid = 1'b1; tick();
        i_valid = 1'b0; tick();
        i_valid = 1'b1; tick();
        chk("first_save", 0, int'(act_save[0]), 1);
        chk("first_save", 1, int'(act_save[1]), 1);
        i_valid = 1'b0; tick();
        chk("save_1cyc", 0, int'(act_save[0]), 0);
        tick();
        chk("taps_lat2", 2, int'(act_taps[2]), 1);
        tick();
        chk("taps_lat3", 0, int'(act_taps[0]), 1);
        tick();
        chk("first_cnt", 0, int'(act_cnt[0]), 1);
        chk("taps_1cyc", 0, int'(act_taps[0]), 0);

        // Decimation: 40 symbols in ADAPT
        nb = 0;
        for (int k = 0; k < 40; k++) begin
            i_valid = 1'b1; tick();
            if (act_save[1]) nb++;
            i_valid = 1'b0; tick();
            if (act_save[1]) nb++;
            i_valid = 1'b1; tick();
            if (act_save[1]) nb++;
            i_valid = 1'b0; tick();
            if (act_save[1]) nb++;
        end
        chk("dec_saves", 1, nb, 10);
        repeat (4) tick();
        chk("dec_cnt",  0, int'(act_cnt[0]), 41);
        chk("sat_cnt",  2, int'(act_cnt[2]), 15);
        chk("dec_ovr",  0, int'(act_ovr[0]), 0);

        // Freeze one cycle after a save
        i_valid = 1'b1; tick();
        i_valid = 1'b0; tick();
        i_valid = 1'b1; tick();
        chk("frz_save", 0, int'(act_save[0]), 1);
        i_valid = 1'b0; tick();
        i_freeze = 1'b1; tick();
        chk("frz_state", 0, int'(act_state[0]), 3);
        tick();
        chk("frz_taps", 0, int'(act_taps[0]), 1);
        ns = 0;
        for (int k = 0; k < 8; k++) begin
            i_valid = 1'b1; tick();
            if (act_save[0] || act_save[1] || act_save[2]) ns++;
            i_valid = 1'b0; tick();
            if (act_save[0] || act_save[1] || act_save[2]) ns++;
        end
        chk("frz_nosave", 0, ns, 0);
        i_freeze = 1'b0; tick();
        chk("unfrz_state", 0, int'(act_state[0]), 2);
        ns = 0;
        for (int k = 0; k < 8; k++) begin
            i_valid = 1'b1; tick();
            if (act_save[0]) ns++;
            i_valid = 1'b0; tick();
            if (act_save[0]) ns++;
        end
        chk("unfrz_saves", 0, ns, 4);
        repeat (4) tick();

        // Overrun: sample every cycle
        chk("pre_ovr", 0, int'(act_ovr[0]), 0);
        i_valid = 1'b1;
        repeat (16) tick();
        i_valid = 1'b0;
        repeat (5) tick();
        chk("ovr_set",   0, int'(act_ovr[0]), 1);
        chk("ovr_clear", 1, int'(act_ovr[1]), 0);
        chk("coincide",  2, int'(act_ovr[2]), 0);
        chk("ovr_cnt",   0, int'(act_cnt[0]), 47);
        chk("sat_hold",  2, int'(act_cnt[2]), 15);

        // Teardown by enable drop with an update pending
        i_valid = 1'b1; tick();
        i_valid = 1'b0; tick();
        i_valid = 1'b1; tick();
        i_enable = 1'b0; i_valid = 1'b0; tick();
        for (int i = 0; i < NCFG; i++) begin
            chk("dis_en_rx", i, int'(act_en_rx[i]), 0);
            chk("dis_state", i, int'(act_state[i]), 0);
            chk("dis_cnt",   i, int'(act_cnt[i]),   0);
            chk("dis_ovr",   i, int'(act_ovr[i]),   0);
        end
        i_valid = 1'b1;
        #1;
        for (int i = 0; i < NCFG; i++) chk("dis_shtr", i, int'(act_en_shtr[i]), 0);
        repeat (4) begin
            tick();
            chk("dis_taps", 0, int'(act_taps[0]), 0);
        end

        // Teardown by asynchronous reset with an update pending
        i_enable = 1'b1;
        repeat (16) tick();
        chk("pre_rst_save", 0, int'(act_save[0]), 1);
        chk("pre_rst_ovr",  0, int'(act_ovr[0]),  1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NCFG; i++) begin
            chk("arst_state", i, int'(act_state[i]),   0);
            chk("arst_en_rx", i, int'(act_en_rx[i]),   0);
            chk("arst_save",  i, int'(act_save[i]),    0);
            chk("arst_taps",  i, int'(act_taps[i]),    0);
            chk("arst_cnt",   i, int'(act_cnt[i]),     0);
            chk("arst_ovr",   i, int'(act_ovr[i]),     0);
            chk("arst_shtr",  i, int'(act_en_shtr[i]), 0);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            chk("arst_taps", 0, int'(act_taps[0]), 0);
        end
        i_enable = 1'b0; i_valid = 1'b0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
